// File: rtl/scf_pkg.sv
// Shared decode constants, enums and the violation record for the SCF shadow stack.
package scf_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_REGIMM  = 6'd1;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] FN_JR      = 6'd8;
    localparam logic [5:0] FN_JALR    = 6'd9;
    localparam logic [4:0] RT_BLTZAL  = 5'd16;
    localparam logic [4:0] RT_BGEZAL  = 5'd17;
    localparam logic [4:0] RA         = 5'd31;

    typedef enum logic [1:0] {
        VC_NONE      = 2'd0,
        VC_MISMATCH  = 2'd1,
        VC_OVERFLOW  = 2'd2,
        VC_UNDERFLOW = 2'd3
    } viol_code_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SLOT  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    typedef struct packed {
        viol_code_e  code;
        logic [31:0] pc;
        logic [31:0] expected;
        logic [31:0] actual;
    } viol_t;

    function automatic logic is_call(input logic [31:0] i);
        return (i[31:26] == OP_JAL) ||
               (i[31:26] == OP_SPECIAL && i[5:0] == FN_JALR) ||
               (i[31:26] == OP_REGIMM && (i[20:16] == RT_BLTZAL || i[20:16] == RT_BGEZAL));
    endfunction

    function automatic logic is_ret(input logic [31:0] i);
        return (i[31:26] == OP_SPECIAL) && (i[5:0] == FN_JR) && (i[25:21] == RA);
    endfunction

endpackage

// File: rtl/scf_ss_lifo.sv
// Circular LIFO: a push when full overwrites the oldest entry and the count saturates.
module scf_ss_lifo
    import scf_pkg::*;
#(
    parameter  int DEPTH = 32,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           top;   // next write slot; wraps onto the oldest entry when full

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[top - AW'(1)];

    always_ff @(posedge clk) begin
        if (push) mem[top] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            top <= top + AW'(1);
            if (!full) count <= count + (AW+1)'(1);
        end else if (pop && !empty) begin
            top   <= top - AW'(1);
            count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/scf_shadow_stack.sv
// Shadow call stack: pushes return addresses on calls, checks the landing PC after the
// delay slot of each return, and reports mismatch/overflow/underflow violations.
module scf_shadow_stack
    import scf_pkg::*;
#(
    parameter int DEPTH        = 32,
    parameter bit HALT_ON_VIOL = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [63:0]             in_pkt,
    input  logic                    clr_alarm,
    output logic                    viol_valid,
    output logic [1:0]              viol_code,
    output logic [31:0]             viol_pc,
    output logic [31:0]             viol_expected,
    output logic [31:0]             viol_actual,
    output logic                    alarm,
    output logic [$clog2(DEPTH):0]  depth
);
    logic [31:0] pc, top_data, exp_reg, ret_pc;
    logic        acc, dec_en, call, ret, pop, full, empty, halted, nv_valid;
    state_e      state, state_nxt;
    viol_t       nv, vq;

    assign pc     = in_pkt[63:32];
    assign acc    = in_valid & in_ready;
    assign dec_en = acc & (state != ST_SLOT);
    assign call   = dec_en & is_call(in_pkt[31:0]);
    assign ret    = dec_en & is_ret(in_pkt[31:0]);
    assign pop    = ret & ~empty;

    scf_ss_lifo #(.DEPTH(DEPTH), .W(32)) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (call),
        .pop   (pop),
        .wdata (pc + 32'd8),
        .rdata (top_data),
        .full  (full),
        .empty (empty),
        .count (depth)
    );

    // A mismatch outranks the decode result of the same (target) packet.
    always_comb begin
        nv       = '0;
        nv_valid = 1'b0;
        if (acc && state == ST_CHECK && pc != exp_reg) begin
            nv_valid    = 1'b1;
            nv.code     = VC_MISMATCH;
            nv.pc       = ret_pc;
            nv.expected = exp_reg;
            nv.actual   = pc;
        end else if (call && full) begin
            nv_valid = 1'b1;
            nv.code  = VC_OVERFLOW;
            nv.pc    = pc;
        end else if (ret && empty) begin
            nv_valid = 1'b1;
            nv.code  = VC_UNDERFLOW;
            nv.pc    = pc;
        end
    end

    always_comb begin
        state_nxt = state;
        if (acc) begin
            if (state == ST_SLOT) state_nxt = ST_CHECK;
            else                  state_nxt = pop ? ST_SLOT : ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            exp_reg    <= '0;
            ret_pc     <= '0;
            viol_valid <= 1'b0;
            vq         <= '0;
            alarm      <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nxt;
            viol_valid <= nv_valid;
            if (pop) begin
                exp_reg <= top_data;
                ret_pc  <= pc;
            end
            if (nv_valid) vq <= nv;
            if (clr_alarm)     alarm <= 1'b0;
            else if (nv_valid) alarm <= 1'b1;
            // Halt trails alarm by one cycle so it drops the cycle after viol_valid.
            halted <= ~clr_alarm & HALT_ON_VIOL & alarm;
        end
    end

    assign in_ready      = ~halted;
    assign viol_code     = vq.code;
    assign viol_pc       = vq.pc;
    assign viol_expected = vq.expected;
    assign viol_actual   = vq.actual;

endmodule

// File: tb/tb_scf_shadow_stack.sv
// Scoreboarded bench: a queue-based reference stack predicts violations, a monitor checks them.
module tb_scf_shadow_stack;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH) + 1;
    localparam int M_RUN = 0, M_SLOT = 1, M_CHECK = 2;
    localparam logic [31:0] I_JAL  = 32'h0C00_0040;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_JALR = 32'h0040_F809;
    localparam logic [31:0] I_BLTZ = 32'h0410_0004;
    localparam logic [31:0] I_BGEZ = 32'h0411_0004;
    localparam logic [31:0] I_NOP  = 32'h0000_0000;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_valid = 1'b0, in_ready, clr_alarm = 1'b0;
    logic [63:0]   in_pkt = '0;
    logic          viol_valid, alarm;
    logic [1:0]    viol_code;
    logic [31:0]   viol_pc, viol_expected, viol_actual;
    logic [DW-1:0] depth;

    scf_shadow_stack #(.DEPTH(DEPTH), .HALT_ON_VIOL(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
        .clr_alarm(clr_alarm), .viol_valid(viol_valid), .viol_code(viol_code),
        .viol_pc(viol_pc), .viol_expected(viol_expected), .viol_actual(viol_actual),
        .alarm(alarm), .depth(depth)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          code;
        logic [31:0] pc;
        logic [31:0] e;
        logic [31:0] a;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] stk[$];
    int          mstate = M_RUN;
    logic [31:0] mexp = '0, mret = '0;
    bit          m_alarm = 1'b0, m_ready = 1'b1;
    int          checks = 0, passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Reference: returns are checked on the packet after the delay slot.
    task automatic model_pkt(input logic [63:0] pkt, output bit viol);
        logic [31:0] pc, ins;
        bit          c, r, have;
        exp_t        e;
        pc   = pkt[63:32];
        ins  = pkt[31:0];
        c    = (ins[31:26] == 3) || (ins[31:26] == 0 && ins[5:0] == 9) ||
               (ins[31:26] == 1 && (ins[20:16] == 16 || ins[20:16] == 17));
        r    = (ins[31:26] == 0) && (ins[5:0] == 8) && (ins[25:21] == 31);
        have = 1'b0;
        e    = '{code: 0, pc: 0, e: 0, a: 0};
        if (mstate == M_SLOT) begin
            mstate = M_CHECK;
        end else begin
            if (mstate == M_CHECK && pc != mexp) begin
                e = '{code: 1, pc: mret, e: mexp, a: pc};
                have = 1'b1;
            end
            mstate = M_RUN;
            if (c) begin
                if (stk.size() == DEPTH) begin
                    void'(stk.pop_front());
                    if (!have) begin e = '{code: 2, pc: pc, e: 0, a: 0}; have = 1'b1; end
                end
                stk.push_back(pc + 32'd8);
            end else if (r) begin
                if (stk.size() == 0) begin
                    if (!have) begin e = '{code: 3, pc: pc, e: 0, a: 0}; have = 1'b1; end
                end else begin
                    mexp   = stk.pop_back();
                    mret   = pc;
                    mstate = M_SLOT;
                end
            end
        end
        if (have) expq.push_back(e);
        viol = have;
    endtask

    // One cycle: check registered state from the last cycle, drive, predict, advance.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins, input bit clr);
        bit viol;
        chk("depth", 64'(depth), 64'(stk.size()));
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("alarm", 64'(alarm), 64'(m_alarm));
        in_valid  = v;
        in_pkt    = {pc, ins};
        clr_alarm = clr;
        viol      = 1'b0;
        if (v && m_ready) model_pkt({pc, ins}, viol);
        m_ready = !(!clr && m_alarm);
        m_alarm = clr ? 1'b0 : (viol ? 1'b1 : m_alarm);
        @(negedge clk);
    endtask

    task automatic model_reset();
        stk.delete();
        expq.delete();
        mstate  = M_RUN;
        m_alarm = 1'b0;
        m_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst && viol_valid) begin
            if (expq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_viol: got code %0d pc %0h, expected no violation", viol_code, viol_pc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("viol_code", 64'(viol_code), 64'(e.code));
                chk("viol_pc", 64'(viol_pc), 64'(e.pc));
                chk("viol_expected", 64'(viol_expected), 64'(e.e));
                chk("viol_actual", 64'(viol_actual), 64'(e.a));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc, ins;
        int          k;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_depth", 64'(depth), 64'd0);
        chk("rst_alarm", 64'(alarm), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_vvalid", 64'(viol_valid), 64'd0);
        chk("rst_vcode", 64'(viol_code), 64'd0);

        // balanced call/return
        step(1, 32'h0040_0100, I_JAL, 0);
        step(1, 32'h0040_0200, I_JR, 0);
        step(1, 32'h0040_0204, I_NOP, 0);
        step(1, 32'h0040_0108, I_NOP, 0);
        step(0, 0, I_NOP, 0);

        // mismatch, then halted until clr_alarm
        step(1, 32'h0040_0100, I_JAL, 0);
        step(1, 32'h0040_0200, I_JR, 0);
        step(1, 32'h0040_0204, I_NOP, 0);
        step(1, 32'h0040_0300, I_NOP, 0);
        step(0, 0, I_NOP, 0);
        repeat (3) step(1, 32'h0040_0400, I_JAL, 0);
        step(0, 0, I_NOP, 1);
        step(0, 0, I_NOP, 0);

        // underflow
        step(1, 32'h0040_0010, I_JR, 0);
        step(0, 0, I_NOP, 1);
        step(0, 0, I_NOP, 0);

        // overflow, drain with matching targets, then one extra return
        for (k = 0; k <= DEPTH; k++) step(1, 32'h1000 + 32'(16 * k), I_JAL, 0);
        step(0, 0, I_NOP, 1);
        chk("ovf_depth", 64'(depth), 64'(DEPTH));
        for (k = DEPTH; k >= 1; k--) begin
            step(1, 32'h2000, I_JR, 0);
            step(1, 32'h2004, I_NOP, 0);
            step(1, 32'h1000 + 32'(16 * k) + 32'd8, I_NOP, 0);
        end
        step(1, 32'h2000, I_JR, 0);
        step(0, 0, I_NOP, 1);
        step(0, 0, I_NOP, 0);

        // target that is itself a call, and a target that is itself a return
        step(1, 32'h0050_0000, I_JAL, 0);
        step(1, 32'h0050_0100, I_JR, 0);
        step(1, 32'h0050_0104, I_NOP, 0);
        step(1, 32'h0050_0008, I_JALR, 0);
        chk("jalr_push", 64'(depth), 64'd1);
        step(1, 32'h0050_0200, I_JR, 0);
        step(1, 32'h0050_0204, I_NOP, 0);
        step(1, 32'h0050_0010, I_NOP, 0);
        step(1, 32'h0060_0000, I_BLTZ, 0);
        step(1, 32'h0060_0100, I_BGEZ, 0);
        step(1, 32'h0060_0200, I_JR, 0);
        step(1, 32'h0060_0204, I_NOP, 0);
        step(1, 32'h0060_0108, I_JR, 0);
        step(1, 32'h0060_010C, I_NOP, 0);
        step(1, 32'h0060_0008, I_NOP, 0);

        // reset while a return check is pending
        step(1, 32'h0070_0000, I_JAL, 0);
        step(1, 32'h0070_0100, I_JR, 0);
        rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_depth", 64'(depth), 64'd0);
        step(1, 32'h0012_3456, I_NOP, 0);
        step(1, 32'h0012_3460, I_JAL, 0);
        step(0, 0, I_NOP, 0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit v, clr;
            v  = ($urandom_range(0, 99) < 90);
            pc = $urandom & 32'hFFFF_FFFC;
            if (mstate == M_CHECK && $urandom_range(0, 9) < 8) pc = mexp;
            case ($urandom_range(0, 9))
                0:       ins = I_JAL | ($urandom & 32'h03FF_FFFF);
                1:       ins = I_JALR;
                2:       ins = ($urandom_range(0, 1) == 0) ? I_BLTZ : I_BGEZ;
                3, 4, 5: ins = I_JR;
                6:       ins = 32'h0220_0008;
                default: ins = $urandom;
            endcase
            clr = m_alarm ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            step(v, pc, ins, clr);
        end
        step(0, 0, I_NOP, 1);
        step(0, 0, I_NOP, 0);
        chk("pending_viol", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
